button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 171 +++++++++++++++++
 tb/tb_button_conditioner.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced push-button conditioner with press/release/long-press strobes
module button_conditioner #(
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd1_000_000,
    parameter logic [31:0] LONG_CYCLES     = 32'd100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_n,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    // Terminal counts; the counter never runs past these.
    localparam logic [31:0] DEB_LAST  = DEBOUNCE_CYCLES - 32'd1;
    localparam logic [31:0] LONG_LAST = LONG_CYCLES - 32'd1;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        LONG_HELD,
        RELEASE_WAIT
    } state_e;

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        long_done_q, long_done_d;
    logic        btn_level_q, btn_level_d;
    logic        press_pulse_q, press_pulse_d;
    logic        release_pulse_q, release_pulse_d;
    logic        long_pulse_q, long_pulse_d;
    logic [7:0]  press_count_q, press_count_d;

    logic        pressed;

    // Two-flop synchronizer; idles at 1 (released) so reset never looks like a press.
    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
    end

    assign pressed = ~sync2_q;

    // Next-state, shared counter and registered-output decode.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        long_done_d     = long_done_q;
        btn_level_d     = btn_level_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        long_pulse_d    = 1'b0;
        press_count_d   = press_count_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pressed) begin
                    state_d = PRESS_WAIT;
                end
            end

            PRESS_WAIT: begin
                if (!pressed) begin
                    // Bounce: drop back and requalify from scratch.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d       = PRESSED;
                    cnt_d         = '0;
                    press_pulse_d = 1'b1;
                    btn_level_d   = 1'b1;
                    press_count_d = press_count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            PRESSED: begin
                if (!pressed) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    // Counter is left at its limit; LONG_HELD freezes it.
                    state_d      = LONG_HELD;
                    long_pulse_d = 1'b1;
                    long_done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            LONG_HELD: begin
                if (!pressed) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end

            RELEASE_WAIT: begin
                if (pressed) begin
                    // Release bounce: resume the press without any strobe.
                    state_d = long_done_q ? LONG_HELD : PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d         = IDLE;
                    cnt_d           = '0;
                    release_pulse_d = 1'b1;
                    btn_level_d     = 1'b0;
                    long_done_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // All state and outputs, asynchronously cleared by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q         <= 1'b1;
            sync2_q         <= 1'b1;
            state_q         <= IDLE;
            cnt_q           <= '0;
            long_done_q     <= 1'b0;
            btn_level_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
            press_count_q   <= 8'd0;
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            long_done_q     <= long_done_d;
            btn_level_q     <= btn_level_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_pulse_q    <= long_pulse_d;
            press_count_q   <= press_count_d;
        end
    end

    assign btn_level     = btn_level_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_pulse    = long_pulse_q;
    assign press_count   = press_count_q;

    // Strobes are mutually exclusive and the counter stays within its limits.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0({press_pulse_q, release_pulse_q, long_pulse_q}))
                else $error("pulse overlap");
            assert ((cnt_q <= DEB_LAST) || (cnt_q <= LONG_LAST))
                else $error("counter beyond limit");
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner
module tb_button_conditioner;

    localparam int D = 4;
    localparam int L = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_n;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    int n_vec = 0;
    int n_err = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(32'(D)),
        .LONG_CYCLES    (32'(L))
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_n        (btn_n),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    // Reference model: the debounced level flips once D+1 consecutive synchronized
    // samples disagree with it; a long press fires L samples after the press anchor
    // (acceptance, or the first pressed sample after a release bounce), once per press.
    bit       m_p1, m_p2;
    bit       m_level, m_press, m_rel, m_long, m_long_done, m_anchor;
    int       m_run, m_hold;
    bit [7:0] m_count;

    function automatic void model_reset();
        m_p1 = 1'b1; m_p2 = 1'b1;
        m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
        m_long_done = 1'b0; m_anchor = 1'b0;
        m_run = 0; m_hold = 0; m_count = 8'd0;
    endfunction

    function automatic void model_step(input bit b);
        bit s;
        s  = !m_p2;
        m_p2 = m_p1;
        m_p1 = b;
        m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
        m_run = (s != m_level) ? m_run + 1 : 0;
        if (m_run == D + 1) begin
            m_run   = 0;
            m_level = s;
            if (s) begin
                m_press  = 1'b1;
                m_count  = m_count + 8'd1;
                m_hold   = 0;
                m_anchor = 1'b0;
            end else begin
                m_rel       = 1'b1;
                m_long_done = 1'b0;
            end
        end else if (m_level) begin
            if (s) begin
                if (m_anchor) begin
                    m_hold   = 0;
                    m_anchor = 1'b0;
                end else begin
                    m_hold++;
                    if (m_hold == L && !m_long_done) begin
                        m_long      = 1'b1;
                        m_long_done = 1'b1;
                    end
                end
            end else begin
                m_anchor = 1'b1;
            end
        end
    endfunction

    int acc_press, acc_rel, acc_long;

    task automatic check_model();
        n_vec++;
        if ({btn_level, press_pulse, release_pulse, long_pulse, press_count} !==
            {m_level, m_press, m_rel, m_long, m_count}) begin
            n_err++;
            $display("FAIL model t=%0t got lvl/pr/rl/lg/cnt=%b%b%b%b/%0d expected %b%b%b%b/%0d",
                     $time, btn_level, press_pulse, release_pulse, long_pulse, press_count,
                     m_level, m_press, m_rel, m_long, m_count);
        end
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        if ({btn_level, press_pulse, release_pulse, long_pulse, press_count} !== 12'd0) begin
            n_err++;
            $display("FAIL %s got lvl/pr/rl/lg/cnt=%b%b%b%b/%0d expected all zero",
                     name, btn_level, press_pulse, release_pulse, long_pulse, press_count);
        end
    endtask

    task automatic cycle(input bit b);
        btn_n = b;
        @(posedge clk);
        model_step(b);
        #1;
        check_model();
        acc_press += int'(press_pulse);
        acc_rel   += int'(release_pulse);
        acc_long  += int'(long_pulse);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("reset_immediate");
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit b;
        int n;
        bit lvl;
        int np;
        int nr;
        int nl;
        int cnt;
    } row_t;

    row_t rows[$];

    task automatic run_row(input row_t r, input string name);
        acc_press = 0; acc_rel = 0; acc_long = 0;
        for (int k = 0; k < r.n; k++) cycle(r.b);
        n_vec++;
        if (btn_level !== r.lvl || acc_press != r.np || acc_rel != r.nr ||
            acc_long != r.nl || press_count !== 8'(r.cnt)) begin
            n_err++;
            $display("FAIL %s got lvl=%b pr=%0d rl=%0d lg=%0d cnt=%0d expected lvl=%b pr=%0d rl=%0d lg=%0d cnt=%0d",
                     name, btn_level, acc_press, acc_rel, acc_long, press_count,
                     r.lvl, r.np, r.nr, r.nl, r.cnt);
        end
    endtask

    initial begin
        int tot_press, tot_rel;
        bit b;

        rst_n = 1'b0;
        btn_n = 1'b1;
        model_reset();
        #2;
        check_zero("reset_async");
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // {btn_n, cycles, level at end, press/release/long pulses in row, count at end}
        rows.push_back('{1'b1,  5, 1'b0, 0, 0, 0, 0});   // idle
        rows.push_back('{1'b0,  7, 1'b1, 1, 0, 0, 1});   // clean press, strobe at edge 6
        rows.push_back('{1'b0,  9, 1'b1, 0, 0, 0, 1});   // edges 7..15
        rows.push_back('{1'b0,  1, 1'b1, 0, 0, 1, 1});   // long at edge 16
        rows.push_back('{1'b0, 13, 1'b1, 0, 0, 0, 1});   // edges 17..29, no second long
        rows.push_back('{1'b1,  6, 1'b1, 0, 0, 0, 1});   // release edges 30..35
        rows.push_back('{1'b1,  1, 1'b0, 0, 1, 0, 1});   // release at edge 36
        rows.push_back('{1'b1,  4, 1'b0, 0, 0, 0, 1});
        rows.push_back('{1'b0,  3, 1'b0, 0, 0, 0, 1});   // bounce: low 3
        rows.push_back('{1'b1,  1, 1'b0, 0, 0, 0, 1});   // high 1
        rows.push_back('{1'b0,  6, 1'b0, 0, 0, 0, 1});   // edges 4..9
        rows.push_back('{1'b0,  1, 1'b1, 1, 0, 0, 2});   // press at edge 10
        rows.push_back('{1'b1,  6, 1'b1, 0, 0, 0, 2});
        rows.push_back('{1'b1,  1, 1'b0, 0, 1, 0, 2});
        rows.push_back('{1'b1,  3, 1'b0, 0, 0, 0, 2});
        rows.push_back('{1'b0,  7, 1'b1, 1, 0, 0, 3});   // long press then release bounce
        rows.push_back('{1'b0, 10, 1'b1, 0, 0, 1, 3});
        rows.push_back('{1'b0,  3, 1'b1, 0, 0, 0, 3});
        rows.push_back('{1'b1,  2, 1'b1, 0, 0, 0, 3});   // 2-cycle release glitch
        rows.push_back('{1'b0, 20, 1'b1, 0, 0, 0, 3});   // back to long-held, silent
        rows.push_back('{1'b1,  6, 1'b1, 0, 0, 0, 3});
        rows.push_back('{1'b1,  1, 1'b0, 0, 1, 0, 3});
        rows.push_back('{1'b1,  3, 1'b0, 0, 0, 0, 3});
        rows.push_back('{1'b0,  4, 1'b0, 0, 0, 0, 3});   // D-sample press glitch rejected
        rows.push_back('{1'b1,  8, 1'b0, 0, 0, 0, 3});
        rows.push_back('{1'b0,  7, 1'b1, 1, 0, 0, 4});
        rows.push_back('{1'b1,  4, 1'b1, 0, 0, 0, 4});   // D-sample release glitch rejected
        rows.push_back('{1'b0,  3, 1'b1, 0, 0, 0, 4});
        rows.push_back('{1'b1,  7, 1'b0, 0, 1, 0, 4});
        rows.push_back('{1'b1,  3, 1'b0, 0, 0, 0, 4});

        foreach (rows[i]) run_row(rows[i], $sformatf("row%0d", i));

        // Reset in PRESS_WAIT with cnt==2, then full requalification with btn held low.
        for (int k = 0; k < 5; k++) cycle(1'b0);
        do_reset();
        run_row('{1'b0, 6, 1'b0, 0, 0, 0, 0}, "reset_requal_wait");
        run_row('{1'b0, 1, 1'b1, 1, 0, 0, 1}, "reset_requal_press");
        run_row('{1'b1, 10, 1'b0, 0, 1, 0, 1}, "reset_requal_release");

        // 256 press/release cycles from a fresh reset: count wraps to zero.
        btn_n = 1'b1;
        do_reset();
        tot_press = 0; tot_rel = 0;
        for (int i = 0; i < 256; i++) begin
            acc_press = 0; acc_rel = 0; acc_long = 0;
            for (int k = 0; k < 7; k++) cycle(1'b0);
            for (int k = 0; k < 7; k++) cycle(1'b1);
            tot_press += acc_press;
            tot_rel   += acc_rel;
            if (i == 254) begin
                n_vec++;
                if (press_count !== 8'd255) begin
                    n_err++;
                    $display("FAIL wrap_255 got %0d expected 255", press_count);
                end
            end
        end
        n_vec++;
        if (press_count !== 8'd0 || tot_press != 256 || tot_rel != 256) begin
            n_err++;
            $display("FAIL wrap got cnt=%0d presses=%0d releases=%0d expected cnt=0 presses=256 releases=256",
                     press_count, tot_press, tot_rel);
        end

        // Random run lengths against the reference model, with one reset mid-stream.
        for (int r = 0; r < 300; r++) begin
            int len;
            b   = 1'($urandom_range(0, 1));
            len = (r % 3 == 0) ? int'($urandom_range(1, 2 * D + 2))
                               : int'($urandom_range(1, L + D + 6));
            for (int k = 0; k < len; k++) cycle(b);
            if (r == 150) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
